// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared ALU one-hot codes, FSM states, opcodes, mux codes and control bundle
package mc_ctrl_pkg;
  localparam logic [11:0] ALU_ADD = 12'h800, ALU_SUB = 12'h400, ALU_SLT = 12'h200, ALU_SLTU = 12'h100;
  localparam logic [11:0] ALU_AND = 12'h080, ALU_NOR = 12'h040, ALU_OR = 12'h020, ALU_XOR = 12'h010;
  localparam logic [11:0] ALU_SLL = 12'h008, ALU_SRL = 12'h004, ALU_SRA = 12'h002, ALU_LUI = 12'h001;
  localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EX = 3'd2, ST_MEM = 3'd3, ST_WB = 3'd4;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04, F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07, F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;
  localparam logic [1:0] SRCA_PC = 2'd0, SRCA_RS = 2'd1, SRCA_SHAMT = 2'd2;
  localparam logic [2:0] SRCB_RT = 3'd0, SRCB_4 = 3'd1, SRCB_SEXT = 3'd2, SRCB_ZEXT = 3'd3, SRCB_BR = 3'd4;
  localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2;
  typedef enum logic [2:0] {CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_J, CLS_ILL} cls_t;
  typedef struct packed {
    logic [11:0] alu_control;
    logic [1:0]  alu_src_a;
    logic [2:0]  alu_src_b;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_src;
    logic        reg_write;
    logic        mem_to_reg;
    logic        reg_dst;
    logic        illegal;
  } ctrl_t;
endpackage

// File: rtl/mc_ctrl_inst_decode.sv
// inst_decode: classifies an instruction and picks its EX-stage ALU op and operand selects
module inst_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output cls_t        cls,
  output logic [11:0] alu_control,
  output logic [1:0]  alu_src_a,
  output logic [2:0]  alu_src_b,
  output logic        illegal
);
  logic [5:0] op, funct;
  logic unused_fields;
  assign op = inst[31:26];
  assign funct = inst[5:0];
  assign unused_fields = ^inst[25:6];
  // opcode/funct lookup; anything unlisted falls through as illegal
  always_comb begin
    cls = CLS_ILL;
    alu_control = '0;
    alu_src_a = SRCA_RS;
    alu_src_b = SRCB_RT;
    case (op)
      OP_RTYPE: begin
        cls = CLS_R;
        case (funct)
          F_ADDU: alu_control = ALU_ADD;
          F_SUBU: alu_control = ALU_SUB;
          F_SLT:  alu_control = ALU_SLT;
          F_SLTU: alu_control = ALU_SLTU;
          F_AND:  alu_control = ALU_AND;
          F_OR:   alu_control = ALU_OR;
          F_XOR:  alu_control = ALU_XOR;
          F_NOR:  alu_control = ALU_NOR;
          F_SLL:  begin alu_control = ALU_SLL; alu_src_a = SRCA_SHAMT; end
          F_SRL:  begin alu_control = ALU_SRL; alu_src_a = SRCA_SHAMT; end
          F_SRA:  begin alu_control = ALU_SRA; alu_src_a = SRCA_SHAMT; end
          F_SLLV: alu_control = ALU_SLL;
          F_SRLV: alu_control = ALU_SRL;
          F_SRAV: alu_control = ALU_SRA;
          default: cls = CLS_ILL;
        endcase
      end
      OP_ADDIU: begin cls = CLS_I; alu_control = ALU_ADD;  alu_src_b = SRCB_SEXT; end
      OP_SLTI:  begin cls = CLS_I; alu_control = ALU_SLT;  alu_src_b = SRCB_SEXT; end
      OP_SLTIU: begin cls = CLS_I; alu_control = ALU_SLTU; alu_src_b = SRCB_SEXT; end
      OP_ANDI:  begin cls = CLS_I; alu_control = ALU_AND;  alu_src_b = SRCB_ZEXT; end
      OP_ORI:   begin cls = CLS_I; alu_control = ALU_OR;   alu_src_b = SRCB_ZEXT; end
      OP_XORI:  begin cls = CLS_I; alu_control = ALU_XOR;  alu_src_b = SRCB_ZEXT; end
      OP_LUI:   begin cls = CLS_I; alu_control = ALU_LUI;  alu_src_b = SRCB_ZEXT; end
      OP_LW, OP_SW: begin
        cls = op == OP_LW ? CLS_LW : CLS_SW;
        alu_control = ALU_ADD;
        alu_src_b = SRCB_SEXT;
      end
      OP_BEQ, OP_BNE: begin
        cls = op == OP_BEQ ? CLS_BEQ : CLS_BNE;
        alu_control = ALU_SUB;
      end
      OP_J: cls = CLS_J;
      default: cls = CLS_ILL;
    endcase
  end
  assign illegal = cls == CLS_ILL;
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle IF/ID/EX/MEM/WB sequencer driving the MIPS datapath controls
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic [11:0] alu_control,
  output logic [1:0]  alu_src_a,
  output logic [2:0]  alu_src_b,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        illegal
);
  logic [2:0] state_q, state_d;
  cls_t cls;
  logic [11:0] dec_alu;
  logic [1:0] dec_src_a;
  logic [2:0] dec_src_b;
  logic dec_illegal;
  ctrl_t c;
  inst_decode u_dec (
    .inst(inst),
    .cls(cls),
    .alu_control(dec_alu),
    .alu_src_a(dec_src_a),
    .alu_src_b(dec_src_b),
    .illegal(dec_illegal)
  );
  // per-state control outputs and next-state selection
  always_comb begin
    c = '0;
    state_d = state_q;
    case (state_q)
      ST_IF: begin
        c.mem_req = 1'b1;
        if (mem_ready) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          c.alu_control = ALU_ADD;
          c.alu_src_b = SRCB_4;
          state_d = ST_ID;
        end
      end
      ST_ID: begin
        c.alu_control = ALU_ADD;
        c.alu_src_b = SRCB_BR;
        c.pc_write = cls == CLS_J;
        c.pc_src = cls == CLS_J ? PC_JUMP : PC_ALU;
        c.illegal = dec_illegal;
        state_d = (cls == CLS_J || dec_illegal) ? ST_IF : ST_EX;
      end
      ST_EX: begin
        c.alu_control = dec_alu;
        c.alu_src_a = dec_src_a;
        c.alu_src_b = dec_src_b;
        if (cls == CLS_BEQ || cls == CLS_BNE) begin
          c.pc_write = cls == CLS_BEQ ? alu_zero : !alu_zero;
          c.pc_src = PC_ALUOUT;
        end
        state_d = (cls == CLS_BEQ || cls == CLS_BNE) ? ST_IF :
                  (cls == CLS_LW || cls == CLS_SW) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        c.mem_req = 1'b1;
        c.mem_addr_src = 1'b1;
        c.mem_we = cls == CLS_SW;
        if (mem_ready) state_d = cls == CLS_SW ? ST_IF : ST_WB;
      end
      ST_WB: begin
        c.reg_write = 1'b1;
        c.mem_to_reg = cls == CLS_LW;
        c.reg_dst = cls == CLS_R;
        state_d = ST_IF;
      end
      default: state_d = ST_IF;
    endcase
    if (rst) state_d = ST_IF;
  end
  // state register; reset folded into state_d
  always_ff @(posedge clk) state_q <= state_d;
  assign {alu_control, alu_src_a, alu_src_b, ir_write, pc_write, pc_src, mem_req, mem_we,
          mem_addr_src, reg_write, mem_to_reg, reg_dst, illegal} = rst ? '0 : c;
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the lab2 MIPS datapath; sits directly upstream of `simple_alu` and drives its 12-bit one-hot `alu_control` plus every datapath mux and enable. Each instruction is sequenced through fetch, decode, execute, memory and writeback states. Memory access uses a req/ready handshake. The ALU `zero` output is consumed for `beq`/`bne` resolution.

## Interface
Parameters: none.
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- inst  in  32  current IR contents (valid from ID onward)
- mem_ready  in  1  memory completes request this cycle; ignored when mem_req=0
- alu_zero  in  1  ALU `zero` flag
- alu_control  out  12  one-hot: add 0x800, sub 0x400, slt 0x200, sltu 0x100, and 0x080, nor 0x040, or 0x020, xor 0x010, sll 0x008, srl 0x004, sra 0x002, lui 0x001
- alu_src_a  out  2  0=PC, 1=rs, 2=zero-extended shamt
- alu_src_b  out  3  0=rt, 1=const 4, 2=sext imm, 3=zext imm, 4=sext imm<<2
- ir_write, pc_write  out  1  register enables
- pc_src  out  2  0=ALU result, 1=ALUOut (branch target), 2={PC[31:28],inst[25:0],2'b00}
- mem_req, mem_we, mem_addr_src  out  1  request, write, address select (0=PC, 1=ALUOut)
- reg_write, mem_to_reg  out  1  RF write enable, WB data select (1=MDR)
- reg_dst  out  1  0=rt, 1=rd
- illegal  out  1  one-cycle pulse on undecodable instruction

## Operation
- States: IF, ID, EX, MEM, WB; reset state IF.
- IF: mem_req=1, mem_addr_src=0; hold until mem_ready. On mem_ready: ir_write=1, pc_write=1, pc_src=0, alu add PC+4 (src_a=0, src_b=1) -> ID.
- ID: alu add PC + sext<<2 (src_b=4), result latched into ALUOut by datapath. `j` (op 0x02): pc_write=1, pc_src=2 -> IF. Illegal opcode/funct: illegal=1 -> IF. Otherwise -> EX.
- EX, R-type (op 0): addu 0x21, subu 0x23, slt 0x2A, sltu 0x2B, and 0x24, or 0x25, xor 0x26, nor 0x27, src_a=1, src_b=0; sll 0x00, srl 0x02, sra 0x03, src_a=2, src_b=0; sllv 0x04, srlv 0x06, srav 0x07, src_a=1, src_b=0 -> WB.
- EX, I-type: addiu/slti/sltiu use sext, andi/ori/xori use zext, lui uses zext -> WB. lw/sw: add rs+sext -> MEM.
- EX, beq/bne: sub rs-rt; pc_write = alu_zero (beq) or !alu_zero (bne), pc_src=1 -> IF.
- MEM: mem_req=1, mem_addr_src=1, mem_we=1 for sw; hold until mem_ready; sw -> IF, lw -> WB.
- WB: reg_write=1; mem_to_reg=1 for lw only; reg_dst=1 for R-type only -> IF.
- Outputs are a function of state and decoded inst; all outputs not listed for a state are 0.

## Timing
- During rst=1 and in the cycle reset releases (state IF): all outputs 0 except IF's mem_req=1, mem_addr_src=0. While rst=1, all outputs forced 0.
- Reset mid-operation (any state, including MEM with mem_req high): next state IF; no pc_write/reg_write issued in the reset cycle.
- Cycles (zero-wait memory): j 2, beq/bne 3, sw 4, ALU ops 4, lw 5; each mem wait cycle adds 1.
- mem_req stays high and address select stable until mem_ready; mem_ready with mem_req=0 has no effect.
- illegal asserts exactly one cycle (ID) per illegal instruction.

## Structure
- Shared header `mips_defs.vh`: ALU one-hot constants, state encoding, opcode and funct localparams, alu_src_a/alu_src_b/pc_src codes; `simple_alu` decode uses the same ALU constants.
- Sub-module `inst_decode` (combinational): inst -> instruction class, alu_control, src selects, illegal. `mc_ctrl` holds the FSM only.

## Test plan
- Reset then addu $3,$1,$2 (0x00221821), mem_ready=1 -> IF/ID/EX/WB in 4 cycles; EX alu_control=0x800, src_a=1, src_b=0; WB reg_write=1, reg_dst=1.
- sll $3,$2,4 (0x00021900) -> EX alu_control=0x008, src_a=2; ori immediate case -> src_b=3, alu_control=0x020.
- lw $2,4($1) (0x8C220004), mem_ready low 3 cycles in MEM -> mem_req held, mem_addr_src=1; total 8 cycles; WB mem_to_reg=1, reg_dst=0.
- beq (0x10220003) with alu_zero=1 -> EX pc_write=1, pc_src=1, alu_control=0x400; with alu_zero=0 -> pc_write=0; bne inverse.
- j 0x100 (0x08000100) -> ID pc_write=1, pc_src=2, back to IF after 2 cycles; 0xFC000000 -> illegal pulse 1 cycle, no reg_write.
- rst asserted during MEM of sw -> all outputs 0 that cycle, state IF next, no mem_we afterwards.
